// File: rtl/aes_spi_sequencer_if.sv
// Bus bundle between the AES SPI sequencer, its requester/consumer
// and the SPI_Main master it drives.
interface aes_spi_sequencer_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         key_update;
  logic [1:0]   key_size;
  logic [255:0] key;
  logic [127:0] plaintext;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] ct_data;
  logic         spi_start;
  logic [257:0] spi_tx;
  logic [127:0] spi_rx;
  logic         spi_done;

  // Sequencer side.
  modport master (
    input  cmd_valid, key_update, key_size, key, plaintext,
    input  ct_ready, spi_rx, spi_done,
    output cmd_ready, ct_valid, ct_data, spi_start, spi_tx
  );

  // Requester / consumer / SPI_Main side.
  modport slave (
    output cmd_valid, key_update, key_size, key, plaintext,
    output ct_ready, spi_rx, spi_done,
    input  cmd_ready, ct_valid, ct_data, spi_start, spi_tx
  );
endinterface

// File: rtl/aes_spi_sequencer.sv
// Turns one encrypt request into key/msg/read SPI frames for an
// AES_Encrypt core and returns the ciphertext on a valid/ready port.
module aes_spi_sequencer #(
  parameter int START_CYCLES   = 10,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 12
) (
  input  logic            clk,
  input  logic            rst,
  aes_spi_sequencer_if.master bus,
  output logic            error,
  output logic            busy
);

  typedef enum logic [3:0] {
    IDLE,
    KEY_START,
    KEY_WAIT,
    MSG_START,
    MSG_WAIT,
    GAP,
    RD_START,
    RD_WAIT,
    OUT
  } state_t;

  localparam logic [TO_W-1:0] START_LAST = TO_W'(START_CYCLES - 1);
  localparam logic [TO_W-1:0] GAP_LAST   = TO_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  state_t          nxt;
  logic [TO_W-1:0] cnt;
  logic            done_q;
  logic            done_edge;
  logic            key_loaded;
  logic            accept;
  logic            bad_size;
  logic            timeout;
  logic            err_set;
  logic [127:0]    pt_r;
  logic [255:0]    key_m;

  assign accept    = bus.cmd_valid & bus.cmd_ready;
  assign bad_size  = (bus.key_size == 2'b11);
  assign done_edge = bus.spi_done & ~done_q;
  assign err_set   = (accept & bad_size) | timeout;

  // Right-justified key with unused upper bits forced to zero.
  always_comb begin
    key_m = bus.key;
    if (bus.key_size == 2'b00)
      key_m[255:128] = '0;
    else if (bus.key_size == 2'b01)
      key_m[255:192] = '0;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Next state, handshake outputs and timeout detection.
  always_comb begin
    nxt           = state;
    timeout       = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.ct_valid  = 1'b0;
    bus.spi_start = 1'b0;
    busy          = 1'b1;
    unique case (state)
      IDLE: begin
        busy          = 1'b0;
        bus.cmd_ready = 1'b1;
        if (accept && !bad_size)
          nxt = (bus.key_update || !key_loaded)
              ? KEY_START : MSG_START;
      end
      KEY_START: begin
        bus.spi_start = 1'b1;
        if (cnt == START_LAST) nxt = KEY_WAIT;
      end
      MSG_START: begin
        bus.spi_start = 1'b1;
        if (cnt == START_LAST) nxt = MSG_WAIT;
      end
      RD_START: begin
        bus.spi_start = 1'b1;
        if (cnt == START_LAST) nxt = RD_WAIT;
      end
      KEY_WAIT, MSG_WAIT, RD_WAIT: begin
        if (done_edge) begin
          if (state == KEY_WAIT)
            nxt = MSG_START;
          else if (state == MSG_WAIT)
            nxt = GAP;
          else
            nxt = OUT;
        end else if (cnt == TO_LAST) begin
          nxt     = IDLE;
          timeout = 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) nxt = RD_START;
      end
      OUT: begin
        bus.ct_valid = 1'b1;
        if (bus.ct_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Per-state cycle counter, restarted on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (nxt != state || state == IDLE || state == OUT)
      cnt <= '0;
    else
      cnt <= cnt + TO_W'(1);
  end

  // Frame payloads, key tracking, ciphertext capture and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b0;
      error       <= 1'b0;
      key_loaded  <= 1'b0;
      pt_r        <= '0;
      bus.spi_tx  <= '0;
      bus.ct_data <= '0;
    end else begin
      done_q <= bus.spi_done;
      error  <= err_set;
      if (accept)
        pt_r <= bus.plaintext;
      if (err_set)
        key_loaded <= 1'b0;
      else if (state == KEY_WAIT && done_edge)
        key_loaded <= 1'b1;
      if (state == RD_WAIT && done_edge)
        bus.ct_data <= bus.spi_rx;
      if (nxt != state) begin
        case (nxt)
          KEY_START:
            bus.spi_tx <= {bus.key_size, key_m};
          MSG_START:
            bus.spi_tx <= {130'b0,
              (state == IDLE) ? bus.plaintext : pt_r};
          KEY_WAIT, MSG_WAIT, RD_WAIT:
            bus.spi_tx <= bus.spi_tx;
          default:
            bus.spi_tx <= '0;
        endcase
      end
    end
  end

endmodule
